sar_search_ctrl: RTL and testbench

Successive-approximation search controller that drives the X operand of a magnitude comparator and consumes its one-hot greater/equal/less response. It resolves an unknown WIDTH-bit target (the comparator's Y operand) MSB-first in at most WIDTH comparisons. Each comparison is a request/response handshake, so the comparator may be combinational or multi-cycle. It sits between system control (start/done) and a comparator built from one-bit comparator cells.

---
 rtl/sar_search_ctrl.sv | 129 ++++++++++++
 tb/tb_sar_search_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives comparator X with an MSB-first
// trial value and resolves the unknown Y operand through a request/response handshake.
`timescale 1ns/1ps

module sar_search_ctrl #(
    parameter int WIDTH = 8,
    parameter int STEPW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    input  logic             cmp_valid,
    input  logic             cmp_g,
    input  logic             cmp_e,
    input  logic             cmp_l,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err,
    output logic [STEPW-1:0] steps
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] guess_q;
    logic [WIDTH-1:0] result_q;
    logic [KW-1:0]    k_q;
    logic [STEPW-1:0] steps_q;
    logic             exact_q;
    logic             err_q;
    logic             done_q;

    logic             code_ok;
    logic [WIDTH-1:0] guess_d;
    logic [WIDTH-1:0] guess_nxt_d;

    // guess_d is the trial after the bit-k decision; guess_nxt_d also arms bit k-1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        code_ok     = ({cmp_g, cmp_e, cmp_l} == 3'b100) ||
                      ({cmp_g, cmp_e, cmp_l} == 3'b010) ||
                      ({cmp_g, cmp_e, cmp_l} == 3'b001);
        guess_d     = guess_q;
        if (cmp_g) begin
            guess_d[k_q] = 1'b0;
        end
        guess_nxt_d = guess_d;
        if (k_q != '0) begin
            guess_nxt_d[k_q - KW'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state updates here are non-blocking so every register samples pre-edge values.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            guess_q  <= '0;
            result_q <= '0;
            k_q      <= '0;
            steps_q  <= '0;
            exact_q  <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        guess_q <= {1'b1, {(WIDTH-1){1'b0}}};
                        k_q     <= KW'(WIDTH - 1);
                        steps_q <= '0;
                        exact_q <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (cmp_valid) begin
                        steps_q <= steps_q + STEPW'(1);
                        if (!code_ok) begin
                            err_q    <= 1'b1;
                            result_q <= guess_q;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (cmp_e) begin
                            exact_q  <= 1'b1;
                            result_q <= guess_q;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (k_q == '0) begin
                            guess_q  <= guess_d;
                            result_q <= guess_d;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            guess_q  <= guess_nxt_d;
                            k_q      <= k_q - KW'(1);
                            state_q  <= S_GAP;
                        end
                    end
                end
                S_GAP:   state_q <= S_REQ;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign guess       = guess_q;
    assign guess_valid = (state_q == S_REQ);
    assign busy        = (state_q == S_REQ) || (state_q == S_GAP);
    assign done        = done_q;
    assign result      = result_q;
    assign exact       = exact_q;
    assign err         = err_q;
    assign steps       = steps_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: a binary-search reference builds the per-cycle timeline
// of each search, and a comparator responder with stalls and fault injection answers requests.
`timescale 1ns/1ps

module tb_sar_search_ctrl;

    localparam int W  = 8;
    localparam int SW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  guess;
    logic          guess_valid;
    logic          cmp_valid;
    logic          cmp_g;
    logic          cmp_e;
    logic          cmp_l;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          exact;
    logic          err;
    logic [SW-1:0] steps;

    sar_search_ctrl #(.WIDTH(W), .STEPW(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .guess       (guess),
        .guess_valid (guess_valid),
        .cmp_valid   (cmp_valid),
        .cmp_g       (cmp_g),
        .cmp_e       (cmp_e),
        .cmp_l       (cmp_l),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .exact       (exact),
        .err         (err),
        .steps       (steps)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One expected cycle of the search timeline, cycle 1 being the cycle after the start edge.
    typedef struct {
        bit           gv;
        bit           busy;
        bit           done;
        logic [W-1:0] guess;
        int           steps;
    } cyc_t;

    cyc_t          trace[$];
    logic [W-1:0]  m_res;
    bit            m_ex;
    bit            m_er;
    int            m_steps;
    logic [W-1:0]  last_res = '0;
    logic [W-1:0]  obs[$];
    int            done_cyc;

    // Comparator responder configuration.
    logic [W-1:0]  tgt_r   = '0;
    int            wait_r  = 0;
    int            inj_r   = 0;
    bit            noise_r = 1'b0;
    int            cmp_idx = 0;
    int            stall   = 0;

    initial begin
        cmp_valid = 1'b0;
        {cmp_g, cmp_e, cmp_l} = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && guess_valid) begin
                if (stall < wait_r) begin
                    stall++;
                    cmp_valid = 1'b0;
                    {cmp_g, cmp_e, cmp_l} = 3'($urandom);
                end else begin
                    stall = 0;
                    cmp_idx++;
                    cmp_valid = 1'b1;
                    if (cmp_idx == inj_r)      {cmp_g, cmp_e, cmp_l} = 3'b101;
                    else if (guess > tgt_r)    {cmp_g, cmp_e, cmp_l} = 3'b100;
                    else if (guess == tgt_r)   {cmp_g, cmp_e, cmp_l} = 3'b010;
                    else                       {cmp_g, cmp_e, cmp_l} = 3'b001;
                end
            end else begin
                cmp_valid = noise_r ? 1'($urandom) : 1'b0;
                {cmp_g, cmp_e, cmp_l} = 3'($urandom);
            end
        end
    end

    // Reference: plain MSB-first binary search over the comparator answers.
    task automatic build_model(input logic [W-1:0] tgt, input int wt, input int inj);
        logic [W-1:0] acc;
        logic [W-1:0] trial;
        int           n;
        trace.delete();
        acc   = '0;
        n     = 0;
        m_ex  = 1'b0;
        m_er  = 1'b0;
        m_res = '0;
        for (int i = W - 1; i >= 0; i--) begin
            trial = acc | (W'(1) << i);
            n++;
            for (int w = 0; w <= wt; w++) trace.push_back('{1'b1, 1'b1, 1'b0, trial, n - 1});
            if (n == inj) begin
                m_er = 1'b1; m_res = trial; break;
            end
            if (trial == tgt) begin
                m_ex = 1'b1; m_res = trial; break;
            end
            if (trial < tgt) acc = trial;
            if (i == 0) begin
                m_res = acc; break;
            end
            trace.push_back('{1'b0, 1'b1, 1'b0, '0, n});
        end
        m_steps = n;
        trace.push_back('{1'b0, 1'b0, 1'b1, '0, n});
    endtask

    task automatic launch();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_search(input logic [W-1:0] tgt, input int wt, input int inj, input bit noise);
        cyc_t t;
        bit   prev_gv;
        build_model(tgt, wt, inj);
        tgt_r = tgt; wait_r = wt; inj_r = inj; noise_r = noise;
        cmp_idx = 0; stall = 0;
        obs.delete();
        done_cyc = 0;
        prev_gv = 1'b0;
        launch();
        for (int c = 1; c <= trace.size(); c++) begin
            @(negedge clk);
            t = trace[c-1];
            check("guess_valid", guess_valid, t.gv);
            check("busy", busy, t.busy);
            check("done", done, t.done);
            check("steps", steps, t.steps);
            if (t.gv) check("guess", guess, t.guess);
            if (t.done) begin
                check("result", result, m_res);
                check("exact", exact, m_ex);
                check("err", err, m_er);
            end else begin
                check("result_held", result, last_res);
                check("exact_busy", exact, 0);
                check("err_busy", err, 0);
            end
            if (guess_valid && !prev_gv) obs.push_back(guess);
            prev_gv = guess_valid;
            if (done && done_cyc == 0) done_cyc = c;
            if (noise) start = 1'($urandom);
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("idle_gv", guess_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_result", result, m_res);
        check("idle_exact", exact, m_ex);
        check("idle_err", err, m_er);
        check("idle_steps", steps, m_steps);
        last_res = m_res;
        noise_r = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_guess"}, guess, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_steps"}, steps, 0);
        check({tag, "_gv"}, guess_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_exact"}, exact, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] a5_seq [8];
        logic [W-1:0] rt;
        int           rw;
        int           ri;
        bit           rn;
        a5_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_rst");

        // Zero-wait comparator, full 8-compare search ending on an equal response.
        run_search(8'hA5, 0, 0, 1'b0);
        check("a5_ncmp", obs.size(), 8);
        for (int i = 0; i < 8 && i < obs.size(); i++) check("a5_guess_seq", obs[i], a5_seq[i]);
        check("a5_result", result, 8'hA5);
        check("a5_exact", exact, 1);
        check("a5_steps", steps, 8);
        check("a5_done_cycle", done_cyc, 16);

        run_search(8'h00, 0, 0, 1'b0);
        check("zero_result", result, 8'h00);
        check("zero_exact", exact, 0);
        check("zero_err", err, 0);
        check("zero_steps", steps, 8);

        run_search(8'h80, 0, 0, 1'b0);
        check("msb_result", result, 8'h80);
        check("msb_exact", exact, 1);
        check("msb_steps", steps, 1);
        check("msb_done_cycle", done_cyc, 2);

        // Three wait cycles per response with junk strobes outside REQ.
        run_search(8'h3C, 3, 0, 1'b1);
        check("w3_result", result, 8'h3C);
        check("w3_exact", exact, 1);
        check("w3_steps", steps, 6);
        check("w3_done_cycle", done_cyc, 30);

        // Illegal g+l code on the third compare: 0x80 g, 0x40 l, then 0x60 is flagged.
        run_search(8'h5A, 0, 3, 1'b0);
        check("inj_err", err, 1);
        check("inj_exact", exact, 0);
        check("inj_steps", steps, 3);
        check("inj_result", result, 8'h60);

        // start toggling while busy and in DONE must not disturb the search.
        run_search(8'h77, 1, 0, 1'b1);
        check("sbusy_result", result, 8'h77);
        check("sbusy_steps", steps, 8);

        // Reset mid-search: immediate return to reset values, no done pulse.
        tgt_r = 8'h33; wait_r = 1; inj_r = 0; noise_r = 1'b0; cmp_idx = 0; stall = 0;
        launch();
        repeat (5) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_busy", busy, 0);
        end
        rst_n = 1'b1;
        last_res = '0;
        @(negedge clk);
        check_reset_values("abort_rel");

        for (int n = 0; n < 30; n++) begin
            rt = W'($urandom);
            rw = $urandom_range(0, 3);
            ri = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W) : 0;
            rn = 1'($urandom_range(0, 1));
            run_search(rt, rw, ri, rn);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
